// File: rtl/beta_regfile.sv
// beta_regfile: Beta 32x32 register file, 2 comb read ports, 1 sync write, R31 reads zero; define BETA_REGFILE_BYPASS_EN for write-through
module beta_regfile #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ra_addr,
  input  logic [4:0]       rb_addr,
  input  logic [4:0]       rc_addr,
  input  logic             ra2sel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             werf,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data
);
  localparam logic [4:0] ZR = 5'(DEPTH - 1);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [4:0]       pb;
  logic             wr;
  assign pb = ra2sel ? rc_addr : rb_addr;
  assign wr = werf && !reset && rc_addr != ZR;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[rc_addr] <= wdata;
    end
  end
`ifdef BETA_REGFILE_BYPASS_EN
  always_comb begin
    ra_data = ra_addr == ZR ? '0 : (wr && ra_addr == rc_addr) ? wdata : regs[ra_addr];
    rb_data = pb == ZR ? '0 : (wr && pb == rc_addr) ? wdata : regs[pb];
  end
`else
  always_comb begin
    ra_data = ra_addr == ZR ? '0 : regs[ra_addr];
    rb_data = pb == ZR ? '0 : regs[pb];
  end
`endif
endmodule
